// File: rtl/core_pipe_ctrl_pkg.sv
// core_pipe_ctrl_pkg: shared constants, scoreboard entry type and forward-select helper
// Contents:
//   REG_W                    register-address width
//   FWD_RF / FWD_MEM / FWD_WB  operand forward-source codes
//   SB_EX / SB_MEM / SB_WB   scoreboard slot indices (youngest first)
//   sb_entry_t               one in-flight instruction {v, wr, rd, ld}
//   fwd_pick()               youngest-match-wins forward select
package core_pipe_ctrl_pkg;
    localparam int REG_W = 5;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;
    localparam int SB_EX  = 0;
    localparam int SB_MEM = 1;
    localparam int SB_WB  = 2;
    localparam int SB_N   = 3;

    typedef struct packed {
        logic             v;
        logic             wr;
        logic [REG_W-1:0] rd;
        logic             ld;
    } sb_entry_t;

    // A producer in EX is younger than one in MEM, so it wins the forward.
    function automatic logic [1:0] fwd_pick(input logic hit_ex, input logic hit_mem);
        return hit_ex ? FWD_MEM : hit_mem ? FWD_WB : FWD_RF;
    endfunction
endpackage

// File: rtl/core_pipe_ctrl_if.sv
// core_pipe_ctrl_if: decode-side flags in, sequencing controls out
// Signals:
//   ID_*            decode-stage instruction fields (master -> slave)
//   EX_REDIRECT     taken branch/jump resolved in EX (master -> slave)
//   MEM_BUSY        outstanding data-memory access (master -> slave)
//   HOLD/STALL_FE/FLUSH   sequencing controls (slave -> master)
//   FWD_SEL1/2      EX operand forward source (slave -> master)
//   EX/MEM/WB_VALID stage occupancy (slave -> master)
//   STALL_CNT       lost-cycle counter, CNT_W bits (slave -> master)
interface core_pipe_ctrl_if #(parameter int CNT_W = 32);
    import core_pipe_ctrl_pkg::*;
    logic             ID_VALID;
    logic [REG_W-1:0] ID_REG_ARADDR1;
    logic [REG_W-1:0] ID_REG_ARADDR2;
    logic             ID_REG1_MEMREAD;
    logic             ID_REG2_MEMREAD;
    logic [REG_W-1:0] ID_REG_AWADDR;
    logic             ID_REG_AWVALID;
    logic             ID_ISLOAD;
    logic             EX_REDIRECT;
    logic             MEM_BUSY;
    logic             HOLD;
    logic             STALL_FE;
    logic             FLUSH;
    logic [1:0]       FWD_SEL1;
    logic [1:0]       FWD_SEL2;
    logic             EX_VALID;
    logic             MEM_VALID;
    logic             WB_VALID;
    logic [CNT_W-1:0] STALL_CNT;

    modport master (
        output ID_VALID, ID_REG_ARADDR1, ID_REG_ARADDR2, ID_REG1_MEMREAD, ID_REG2_MEMREAD,
               ID_REG_AWADDR, ID_REG_AWVALID, ID_ISLOAD, EX_REDIRECT, MEM_BUSY,
        input  HOLD, STALL_FE, FLUSH, FWD_SEL1, FWD_SEL2, EX_VALID, MEM_VALID, WB_VALID, STALL_CNT
    );

    modport slave (
        input  ID_VALID, ID_REG_ARADDR1, ID_REG_ARADDR2, ID_REG1_MEMREAD, ID_REG2_MEMREAD,
               ID_REG_AWADDR, ID_REG_AWVALID, ID_ISLOAD, EX_REDIRECT, MEM_BUSY,
        output HOLD, STALL_FE, FLUSH, FWD_SEL1, FWD_SEL2, EX_VALID, MEM_VALID, WB_VALID, STALL_CNT
    );
endinterface

// File: rtl/core_pipe_sbmatch.sv
// core_pipe_sbmatch: combinational RAW hit of one source register against one scoreboard entry
// Ports:
//   rs     source register address
//   rd_en  the source is actually read
//   entry  scoreboard entry under test
//   hit    entry holds a live writer of rs (x0 never hits)
module core_pipe_sbmatch
    import core_pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic             rd_en,
    input  sb_entry_t        entry,
    output logic             hit
);
    logic unused_ld;

    assign hit = rd_en & entry.v & entry.wr & (entry.rd == rs) & (rs != '0);
    assign unused_ld = entry.ld;
endmodule

// File: rtl/core_pipe_ctrl.sv
// core_pipe_ctrl: five-stage pipeline hold/stall/flush sequencing with a three-entry scoreboard
// Ports:
//   CLK, RST   core clock, asynchronous active-high reset
//   bus        core_pipe_ctrl_if.slave: decode flags in; HOLD, STALL_FE, FLUSH,
//              FWD_SEL1/2, EX/MEM/WB_VALID, STALL_CNT out
// Parameters:
//   RF_BYPASS  register file forwards a WB write to a same-cycle read
//   CNT_W      stall-counter width
// Build option FORWARDING_EN: defined -> only load-use stalls and FWD_SEL is generated;
// undefined -> every live RAW match stalls and FWD_SEL is tied to FWD_RF.
module core_pipe_ctrl
    import core_pipe_ctrl_pkg::*;
#(
    parameter bit RF_BYPASS = 1'b1,
    parameter int CNT_W     = 32
)(
    input logic               CLK,
    input logic               RST,
    core_pipe_ctrl_if.slave   bus
);
    sb_entry_t        sb [SB_N];
    logic [REG_W-1:0] rs [2];
    logic             rd_en [2];
    logic             hit [2][SB_N];
    logic             hold;
    logic             flush;
    logic             stall;
    logic             hazard;
    logic             enter_v;
    logic [CNT_W-1:0] cnt;
    logic             unused_ok;

    assign rs[0]    = bus.ID_REG_ARADDR1;
    assign rs[1]    = bus.ID_REG_ARADDR2;
    assign rd_en[0] = bus.ID_REG1_MEMREAD;
    assign rd_en[1] = bus.ID_REG2_MEMREAD;

    genvar i, j;
    for (i = 0; i < 2; i++) begin : g_op
        for (j = 0; j < SB_N; j++) begin : g_slot
            core_pipe_sbmatch u_match (
                .rs    (rs[i]),
                .rd_en (rd_en[i]),
                .entry (sb[j]),
                .hit   (hit[i][j])
            );
        end
    end

`ifdef FORWARDING_EN
    // Only a load still in EX cannot be forwarded in time.
    assign hazard = (hit[0][SB_EX] | hit[1][SB_EX]) & sb[SB_EX].ld;
`else
    assign hazard = hit[0][SB_EX] | hit[0][SB_MEM] | hit[1][SB_EX] | hit[1][SB_MEM]
                  | (!RF_BYPASS & (hit[0][SB_WB] | hit[1][SB_WB]));
`endif

    assign hold    = bus.MEM_BUSY;
    assign flush   = bus.EX_REDIRECT & !hold;
    assign stall   = !hold & !flush & bus.ID_VALID & hazard;
    assign enter_v = bus.ID_VALID & !flush & !stall;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sb  <= '{default: '0};
            cnt <= '0;
        end else begin
            if (!hold) begin
                sb[SB_WB]  <= sb[SB_MEM];
                sb[SB_MEM] <= sb[SB_EX];
                sb[SB_EX]  <= '{v: enter_v, wr: bus.ID_REG_AWVALID, rd: bus.ID_REG_AWADDR, ld: bus.ID_ISLOAD};
            end
            if (hold | stall)
                cnt <= cnt + 1'b1;
        end
    end

`ifdef FORWARDING_EN
    logic [1:0] fwd1;
    logic [1:0] fwd2;

    // Selects are decided against the scoreboard as it stands before the advance.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fwd1 <= FWD_RF;
            fwd2 <= FWD_RF;
        end else if (!hold) begin
            fwd1 <= enter_v ? fwd_pick(hit[0][SB_EX], hit[0][SB_MEM]) : FWD_RF;
            fwd2 <= enter_v ? fwd_pick(hit[1][SB_EX], hit[1][SB_MEM]) : FWD_RF;
        end
    end

    assign bus.FWD_SEL1 = fwd1;
    assign bus.FWD_SEL2 = fwd2;
`else
    assign bus.FWD_SEL1 = FWD_RF;
    assign bus.FWD_SEL2 = FWD_RF;
`endif

    assign bus.HOLD      = hold;
    assign bus.FLUSH     = flush;
    assign bus.STALL_FE  = stall;
    assign bus.EX_VALID  = sb[SB_EX].v;
    assign bus.MEM_VALID = sb[SB_MEM].v;
    assign bus.WB_VALID  = sb[SB_WB].v;
    assign bus.STALL_CNT = cnt;

    // Fields that only matter in one build configuration.
    assign unused_ok = ^{hit[0][SB_WB], hit[1][SB_WB], sb[SB_EX].ld, sb[SB_MEM].ld, sb[SB_WB].ld, RF_BYPASS};
endmodule

// File: tb/tb_core_pipe_ctrl.sv
// tb_core_pipe_ctrl: directed test-plan sequences plus random stimulus against an in-flight instruction model
module tb_core_pipe_ctrl;
    localparam bit RF_BYPASS = 1'b1;
`ifdef FORWARDING_EN
    localparam int RAW_STALLS = 0;
    localparam int LU_STALLS  = 1;
    localparam logic [1:0] RAW_FWD = 2'b01;
    localparam logic [1:0] LU_FWD  = 2'b10;
`else
    localparam int RAW_STALLS = RF_BYPASS ? 2 : 3;
    localparam int LU_STALLS  = RF_BYPASS ? 2 : 3;
    localparam logic [1:0] RAW_FWD = 2'b00;
    localparam logic [1:0] LU_FWD  = 2'b00;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    core_pipe_ctrl_if #(.CNT_W(32)) bus();
    core_pipe_ctrl #(.RF_BYPASS(RF_BYPASS), .CNT_W(32)) dut (.CLK(clk), .RST(rst), .bus(bus));

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit       valid;
        bit [4:0] rs1;
        bit       re1;
        bit [4:0] rs2;
        bit       re2;
        bit [4:0] rd;
        bit       wr;
        bit       ld;
        bit       redir;
        bit       busy;
    } stim_t;

    // In-flight instructions, index 0 = youngest (in EX).
    typedef struct {
        bit       v;
        bit       wr;
        bit [4:0] rd;
        bit       ld;
    } instr_t;

    instr_t    pipe [3];
    bit [1:0]  m_fwd1;
    bit [1:0]  m_fwd2;
    bit [31:0] m_cnt;

    function automatic stim_t insn(bit [4:0] rd, bit wr, bit ld, bit [4:0] rs1, bit re1, bit [4:0] rs2, bit re2);
        stim_t s;
        s.valid = 1'b1;
        s.rd = rd;
        s.wr = wr;
        s.ld = ld;
        s.rs1 = rs1;
        s.re1 = re1;
        s.rs2 = rs2;
        s.re2 = re2;
        s.redir = 1'b0;
        s.busy = 1'b0;
        return s;
    endfunction

    function automatic stim_t nop();
        stim_t s = insn(0, 0, 0, 0, 0, 0, 0);
        s.valid = 1'b0;
        return s;
    endfunction

    // Distance to the youngest in-flight producer of rs; 3 when none.
    function automatic int youngest(bit [4:0] rs, bit en);
        if (!en || rs == 0) return 3;
        for (int k = 0; k < 3; k++)
            if (pipe[k].v && pipe[k].wr && pipe[k].rd == rs) return k;
        return 3;
    endfunction

    function automatic bit [1:0] fwd_of(int y);
`ifdef FORWARDING_EN
        return y == 0 ? 2'b01 : y == 1 ? 2'b10 : 2'b00;
`else
        return 2'b00;
`endif
    endfunction

    function automatic bit hazard_of(int y1, int y2);
`ifdef FORWARDING_EN
        return (y1 == 0 || y2 == 0) && pipe[0].ld;
`else
        int lim = RF_BYPASS ? 2 : 3;
        return y1 < lim || y2 < lim;
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0};
        m_fwd1 = 0;
        m_fwd2 = 0;
        m_cnt = 0;
    endtask

    task automatic drive(input stim_t s);
        bus.ID_VALID = s.valid;
        bus.ID_REG_ARADDR1 = s.rs1;
        bus.ID_REG1_MEMREAD = s.re1;
        bus.ID_REG_ARADDR2 = s.rs2;
        bus.ID_REG2_MEMREAD = s.re2;
        bus.ID_REG_AWADDR = s.rd;
        bus.ID_REG_AWVALID = s.wr;
        bus.ID_ISLOAD = s.ld;
        bus.EX_REDIRECT = s.redir;
        bus.MEM_BUSY = s.busy;
    endtask

    // Entered and left at a falling edge; checks registered state, then this cycle's controls.
    task automatic cycle(input stim_t s, output bit st);
        int y1, y2;
        bit eh, ef, es, ent;
        check("ex_valid", bus.EX_VALID, pipe[0].v);
        check("mem_valid", bus.MEM_VALID, pipe[1].v);
        check("wb_valid", bus.WB_VALID, pipe[2].v);
        check("fwd_sel1", bus.FWD_SEL1, m_fwd1);
        check("fwd_sel2", bus.FWD_SEL2, m_fwd2);
        check("stall_cnt", bus.STALL_CNT, m_cnt);
        drive(s);
        #1;
        y1 = youngest(s.rs1, s.re1);
        y2 = youngest(s.rs2, s.re2);
        eh = s.busy;
        ef = s.redir && !s.busy;
        es = !eh && !ef && s.valid && hazard_of(y1, y2);
        check("hold", bus.HOLD, eh);
        check("flush", bus.FLUSH, ef);
        check("stall_fe", bus.STALL_FE, es);
        st = es;
        if (!eh) begin
            ent = s.valid && !ef && !es;
            m_fwd1 = ent ? fwd_of(y1) : 2'b00;
            m_fwd2 = ent ? fwd_of(y2) : 2'b00;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = '{ent, s.wr, s.rd, s.ld};
        end
        if (eh || es) m_cnt++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        bit st;
        repeat (3) cycle(nop(), st);
    endtask

    initial begin
        bit st;
        int n;
        bit [31:0] base;
        stim_t s;
        drive(nop());
        model_reset();
        #1 rst = 1'b1;
        #1;
        check("rst_ex_valid", bus.EX_VALID, 0);
        check("rst_wb_valid", bus.WB_VALID, 0);
        check("rst_fwd1", bus.FWD_SEL1, 0);
        check("rst_cnt", bus.STALL_CNT, 0);
        check("rst_stall", bus.STALL_FE, 0);
        @(negedge clk);
        rst = 1'b0;

        // addi x5,x0,1 ; add x6,x5,x5
        cycle(insn(5, 1, 0, 0, 1, 0, 0), st);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(insn(6, 1, 0, 5, 1, 5, 1), st);
            if (!st) break;
            n++;
        end
        check("raw_stall_len", n, RAW_STALLS);
        check("raw_fwd1", bus.FWD_SEL1, RAW_FWD);
        check("raw_fwd2", bus.FWD_SEL2, RAW_FWD);
        drain();

        // lw x5,0(x1) ; add x6,x5,x0
        cycle(insn(5, 1, 1, 1, 1, 0, 0), st);
        base = m_cnt;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(insn(6, 1, 0, 5, 1, 0, 1), st);
            if (!st) break;
            if (n == 0) check("lu_bubble", bus.EX_VALID, 0);
            n++;
        end
        check("lu_stall_len", n, LU_STALLS);
        check("lu_cnt", bus.STALL_CNT, base + LU_STALLS);
        check("lu_fwd1", bus.FWD_SEL1, LU_FWD);
        drain();

        // Same load-use with MEM_BUSY for 3 cycles starting in the stall cycle
        cycle(insn(5, 1, 1, 1, 1, 0, 0), st);
        base = m_cnt;
        for (int k = 0; k < 3; k++) begin
            s = insn(6, 1, 0, 5, 1, 0, 1);
            s.busy = 1'b1;
            cycle(s, st);
            check("hold_ex_kept", bus.EX_VALID, 1);
            check("hold_mem_kept", bus.MEM_VALID, 0);
        end
        n = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(insn(6, 1, 0, 5, 1, 0, 1), st);
            if (!st) break;
            n++;
        end
        check("hold_stall_len", n, LU_STALLS);
        check("hold_cnt", bus.STALL_CNT, base + 3 + LU_STALLS);
        drain();

        // Redirect while ID has a load-use hazard
        cycle(insn(5, 1, 1, 1, 1, 0, 0), st);
        base = m_cnt;
        s = insn(6, 1, 0, 5, 1, 0, 1);
        s.redir = 1'b1;
        cycle(s, st);
        check("redir_no_stall", st, 0);
        check("redir_bubble", bus.EX_VALID, 0);
        check("redir_cnt", bus.STALL_CNT, base);
        drain();

        // Writes to x0 never create a dependency
        cycle(insn(0, 0, 0, 1, 1, 0, 0), st);
        cycle(insn(7, 1, 0, 0, 1, 0, 1), st);
        check("x0_nowr_stall", st, 0);
        cycle(insn(0, 1, 1, 1, 1, 0, 0), st);
        cycle(insn(7, 1, 0, 0, 1, 0, 1), st);
        check("x0_wr_stall", st, 0);
        drain();

        // Asynchronous reset in the middle of a stall with every stage valid
        cycle(insn(2, 1, 0, 0, 0, 0, 0), st);
        cycle(insn(3, 1, 0, 0, 0, 0, 0), st);
        cycle(insn(5, 1, 1, 1, 1, 0, 0), st);
        drive(insn(6, 1, 0, 5, 1, 0, 1));
        #1;
        check("pre_rst_stall", bus.STALL_FE, 1);
        check("pre_rst_wb", bus.WB_VALID, 1);
        bus.MEM_BUSY = 1'b1;
        bus.EX_REDIRECT = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("mid_rst_ex", bus.EX_VALID, 0);
        check("mid_rst_mem", bus.MEM_VALID, 0);
        check("mid_rst_wb", bus.WB_VALID, 0);
        check("mid_rst_fwd1", bus.FWD_SEL1, 0);
        check("mid_rst_fwd2", bus.FWD_SEL2, 0);
        check("mid_rst_cnt", bus.STALL_CNT, 0);
        check("mid_rst_hold", bus.HOLD, 1);
        check("mid_rst_flush", bus.FLUSH, 0);
        bus.MEM_BUSY = 1'b0;
        #1;
        check("mid_rst_flush2", bus.FLUSH, 1);
        check("mid_rst_stall", bus.STALL_FE, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Random traffic over a small register set to provoke frequent hazards
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                #1;
                check("rnd_rst_ex", bus.EX_VALID, 0);
                check("rnd_rst_cnt", bus.STALL_CNT, 0);
                @(negedge clk);
                rst = 1'b0;
                model_reset();
            end
            s.valid = $urandom_range(0, 9) < 8;
            s.rs1 = 5'($urandom_range(0, 3));
            s.re1 = 1'($urandom_range(0, 1));
            s.rs2 = 5'($urandom_range(0, 3));
            s.re2 = 1'($urandom_range(0, 1));
            s.rd = 5'($urandom_range(0, 3));
            s.wr = s.rd != 0 && $urandom_range(0, 3) != 0;
            s.ld = $urandom_range(0, 9) < 3;
            s.redir = $urandom_range(0, 99) < 8;
            s.busy = $urandom_range(0, 99) < 15;
            cycle(s, st);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
